// File: rtl/block_averaging.sv
// Block averager: downscales a source frame by F=2 or F=4 by summing each FxF block and writing sum/(F*F).
// Latency: F*F+2 cycles per block (F*F fetch cycles, one drain cycle for the last ROM read, one write cycle).
// Flow control: none; the source is a 1-cycle synchronous ROM and the sink accepts every write_en pulse.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   enable              - level run request; dropping it mid-frame aborts to IDLE
//   zoom_level[2:0]     - 1 -> F=2, 0 -> F=4, anything else is ignored (stay in IDLE)
//   pixel_in[7:0]       - ROM data for the read_addr presented on the previous cycle
//   read_addr[14:0]     - registered source address
//   pixel_out[7:0]      - registered block average
//   write_addr[16:0]    - registered destination address
//   write_en            - one-cycle destination write strobe
//   done                - frame complete, held while enable stays high
module block_averaging #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  zoom_level,
  input  logic [7:0]  pixel_in,
  output logic [14:0] read_addr,
  output logic [7:0]  pixel_out,
  output logic [16:0] write_addr,
  output logic        write_en,
  output logic        done
);

  // Counters are sized for the finest factor (F=2), which has the most blocks.
  localparam int BLK_X = IMG_WIDTH_IN / 2;
  localparam int BLK_Y = IMG_HEIGHT_IN / 2;
  localparam int BXW   = (BLK_X > 1) ? $clog2(BLK_X) : 1;
  localparam int BYW   = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      fs_q, fs_d;           // log2(F): 1 for F=2, 2 for F=4
  logic [BXW-1:0]  bx_q, bx_d;
  logic [BYW-1:0]  by_q, by_d;
  logic [1:0]      dx_q, dx_d;           // offset of the address currently on read_addr
  logic [1:0]      dy_q, dy_d;
  logic [11:0]     acc_q, acc_d;
  logic [14:0]     read_addr_q, read_addr_d;
  logic [7:0]      pixel_out_q, pixel_out_d;
  logic [16:0]     write_addr_q, write_addr_d;
  logic            write_en_q, write_en_d;
  logic            done_q, done_d;

  logic            zoom_ok;
  logic [1:0]      f_m1;
  logic            first_fetch;
  logic            last_offset;
  logic            last_bx;
  logic            last_by;
  logic [11:0]     sum_last;

  function automatic logic [14:0] src_addr(
    input logic [1:0]     fs,
    input logic [BXW-1:0] bx,
    input logic [BYW-1:0] by,
    input logic [1:0]     dx,
    input logic [1:0]     dy
  );
    logic [14:0] row;
    logic [14:0] col;
    row = (15'(by) << fs) + 15'(dy);
    col = (15'(bx) << fs) + 15'(dx);
    return (row * 15'(IMG_WIDTH_IN)) + col;
  endfunction

  assign zoom_ok     = (zoom_level == 3'd0) || (zoom_level == 3'd1);
  assign f_m1        = (fs_q == 2'd2) ? 2'd3 : 2'd1;
  // The first fetch cycle of a block has no ROM data for this block yet.
  assign first_fetch = (dx_q == 2'd0) && (dy_q == 2'd0);
  assign last_offset = (dx_q == f_m1) && (dy_q == f_m1);
  assign last_bx     = (bx_q == BXW'((IMG_WIDTH_IN >> fs_q) - 1));
  assign last_by     = (by_q == BYW'((IMG_HEIGHT_IN >> fs_q) - 1));
  // Max 16*255 = 4080 fits in 12 bits.
  assign sum_last    = acc_q + 12'(pixel_in);

  always_comb begin
    state_d      = state_q;
    fs_d         = fs_q;
    bx_d         = bx_q;
    by_d         = by_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    acc_d        = acc_q;
    read_addr_d  = read_addr_q;
    pixel_out_d  = pixel_out_q;
    write_addr_d = write_addr_q;
    write_en_d   = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        read_addr_d = '0;
        if (enable && zoom_ok) begin
          fs_d    = (zoom_level == 3'd1) ? 2'd1 : 2'd2;
          bx_d    = '0;
          by_d    = '0;
          dx_d    = '0;
          dy_d    = '0;
          acc_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (!enable) begin
          state_d     = IDLE;
          bx_d        = '0;
          by_d        = '0;
          dx_d        = '0;
          dy_d        = '0;
          acc_d       = '0;
          read_addr_d = '0;
        end else begin
          if (!first_fetch) begin
            acc_d = acc_q + 12'(pixel_in);
          end
          if (last_offset) begin
            state_d = LAST;
          end else begin
            if (dx_q == f_m1) begin
              dx_d = 2'd0;
              dy_d = dy_q + 2'd1;
            end else begin
              dx_d = dx_q + 2'd1;
            end
            read_addr_d = src_addr(fs_q, bx_q, by_q, dx_d, dy_d);
          end
        end
      end

      LAST: begin
        if (!enable) begin
          state_d     = IDLE;
          bx_d        = '0;
          by_d        = '0;
          dx_d        = '0;
          dy_d        = '0;
          acc_d       = '0;
          read_addr_d = '0;
        end else begin
          acc_d        = sum_last;
          // Divide by F*F = shift by 2*log2(F), truncating.
          pixel_out_d  = 8'(sum_last >> {fs_q, 1'b0});
          write_addr_d = (17'(by_q) * 17'(IMG_WIDTH_IN >> fs_q)) + 17'(bx_q);
          write_en_d   = 1'b1;
          state_d      = WRITE;
        end
      end

      WRITE: begin
        dx_d  = '0;
        dy_d  = '0;
        acc_d = '0;
        if (!enable) begin
          state_d     = IDLE;
          bx_d        = '0;
          by_d        = '0;
          read_addr_d = '0;
        end else if (last_bx && last_by) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          if (last_bx) begin
            bx_d = '0;
            by_d = by_q + 1'b1;
          end else begin
            bx_d = bx_q + 1'b1;
          end
          read_addr_d = src_addr(fs_q, bx_d, by_d, 2'd0, 2'd0);
          state_d     = FETCH;
        end
      end

      DONE: begin
        if (enable) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        read_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fs_q         <= 2'd1;
      bx_q         <= '0;
      by_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      acc_q        <= '0;
      read_addr_q  <= '0;
      pixel_out_q  <= '0;
      write_addr_q <= '0;
      write_en_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fs_q         <= fs_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      acc_q        <= acc_d;
      read_addr_q  <= read_addr_d;
      pixel_out_q  <= pixel_out_d;
      write_addr_q <= write_addr_d;
      write_en_q   <= write_en_d;
      done_q       <= done_d;
    end
  end

  assign read_addr  = read_addr_q;
  assign pixel_out  = pixel_out_q;
  assign write_addr = write_addr_q;
  assign write_en   = write_en_q;
  assign done       = done_q;

endmodule

// File: tb/tb_block_averaging.sv
module tb_block_averaging;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [2:0]  zoom_level;
  logic [7:0]  pixel_in;
  logic [14:0] read_addr;
  logic [7:0]  pixel_out;
  logic [16:0] write_addr;
  logic        write_en;
  logic        done;

  int   n_pass  = 0;
  int   n_total = 0;
  int   wr_cnt  = 0;
  int   wr_log [4];
  int   ra_log [16];
  exp_t exp_q [$];
  exp_t mon_e;
  logic [7:0] img [0:19199];

  block_averaging #(
    .IMG_WIDTH_IN (160),
    .IMG_HEIGHT_IN(120)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .zoom_level(zoom_level),
    .pixel_in  (pixel_in),
    .read_addr (read_addr),
    .pixel_out (pixel_out),
    .write_addr(write_addr),
    .write_en  (write_en),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous source ROM: data appears one cycle after the address.
  always @(posedge clk) pixel_in <= img[read_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Write monitor / scoreboard consumer.
  initial begin
    forever begin
      @(negedge clk);
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(write_en), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(write_addr), 32'(mon_e.addr));
          check("wr_data", 32'(pixel_out), 32'(mon_e.data));
        end
        if (wr_cnt < 4) wr_log[wr_cnt] = int'(pixel_out);
        wr_cnt++;
      end
    end
  end

  // Reference: plain block sum over the image, divided by F*F with truncation.
  task automatic push_expected(input int fs, input int first, input int n);
    int f;
    int wf;
    int bx;
    int by;
    int sum;
    f  = 1 << fs;
    wf = 160 >> fs;
    for (int b = first; b < first + n; b++) begin
      bx  = b % wf;
      by  = b / wf;
      sum = 0;
      for (int dy = 0; dy < f; dy++)
        for (int dx = 0; dx < f; dx++)
          sum += int'(img[(by * f + dy) * 160 + bx * f + dx]);
      exp_q.push_back('{addr: b, data: sum / (f * f)});
    end
  endtask

  task automatic wait_writes(input int n, input int limit);
    int c;
    c = 0;
    while (wr_cnt < n && c < limit) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    check("writes_seen", 32'(wr_cnt), 32'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_addr"},  32'(read_addr),  32'd0);
    check({tag, "_write_addr"}, 32'(write_addr), 32'd0);
    check({tag, "_pixel_out"},  32'(pixel_out),  32'd0);
    check({tag, "_write_en"},   32'(write_en),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  // Start a frame, time it to done, change zoom mid-frame (must be ignored).
  task automatic run_frame(input logic [2:0] z, input logic [2:0] z_alt, input int exp_cyc);
    int cyc;
    cyc = 0;
    @(negedge clk);
    zoom_level = z;
    wr_cnt     = 0;
    enable     = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc <= 16) ra_log[cyc-1] = int'(read_addr);
      if (cyc == 40) zoom_level = z_alt;
    end while (done !== 1'b1 && cyc < exp_cyc + 200);
    check("frame_cycles", 32'(cyc - 1), 32'(exp_cyc));
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("done_held", 32'(done), 32'd1);
      check("done_no_wen", 32'(write_en), 32'd0);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_clears", 32'(done), 32'd0);
  endtask

  initial begin
    int bad;
    int rs [4];
    rs = '{0, 1, 160, 161};

    rst_n      = 1'b0;
    enable     = 1'b0;
    zoom_level = 3'd1;
    for (int a = 0; a < 19200; a++) img[a] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // F=2, uniform 100
    for (int a = 0; a < 19200; a++) img[a] = 8'd100;
    push_expected(1, 0, 4800);
    run_frame(3'd1, 3'd0, 28800);
    check("f2_first_pix", 32'(wr_log[0]), 32'd100);

    // F=4, all 255: address order of block 0 and no accumulator overflow
    for (int a = 0; a < 19200; a++) img[a] = 8'd255;
    push_expected(2, 0, 1200);
    run_frame(3'd0, 3'd5, 21600);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check("f4_read_addr", 32'(ra_log[i*4+j]), 32'(i * 160 + j));
    check("f4_max_pix", 32'(wr_log[0]), 32'd255);

    // Invalid zoom level keeps the block idle
    @(negedge clk);
    zoom_level = 3'd2;
    enable     = 1'b1;
    bad        = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (write_en !== 1'b0 || done !== 1'b0 || read_addr !== 15'd0) bad++;
    end
    check("bad_zoom_idle_cycles", 32'(bad), 32'd0);
    check("bad_zoom_wen", 32'(write_en), 32'd0);
    check("bad_zoom_done", 32'(done), 32'd0);
    @(negedge clk);
    enable = 1'b0;

    // F=2 patterned image; truncation on block 0, saturation-free 255 on block 1; abort in block 10
    for (int a = 0; a < 19200; a++) img[a] = 8'((a * 7 + 3) & 255);
    img[0]   = 8'd1;   img[1]   = 8'd2;   img[160] = 8'd3;   img[161] = 8'd4;
    img[2]   = 8'd255; img[3]   = 8'd255; img[162] = 8'd255; img[163] = 8'd255;
    push_expected(1, 0, 10);
    @(negedge clk);
    zoom_level = 3'd1;
    wr_cnt     = 0;
    enable     = 1'b1;
    wait_writes(10, 200);
    @(negedge clk);
    enable = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("abort_no_wen", 32'(write_en), 32'd0);
    end
    check("abort_ra_cleared", 32'(read_addr), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    check("trunc_pix", 32'(wr_log[0]), 32'd2);
    check("max_pix_f2", 32'(wr_log[1]), 32'd255);

    // Re-enable restarts from block 0, then reset mid-FETCH of block 3
    push_expected(1, 0, 3);
    @(negedge clk);
    wr_cnt = 0;
    enable = 1'b1;
    wait_writes(3, 200);
    @(negedge clk);
    check("pre_reset_ra_busy", 32'(read_addr != 15'd0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    exp_q.delete();
    @(negedge clk);
    push_expected(1, 0, 2);
    wr_cnt = 0;
    rst_n  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("restart_read_addr", 32'(read_addr), 32'(rs[i]));
    end
    wait_writes(2, 100);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_averaging.md
BLOCK_AVERAGING -- requirements
Module: block_averaging

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 SHALL use parameter IMG_WIDTH_IN, default 160: source image width in pixels.
REQ-003 SHALL use parameter IMG_HEIGHT_IN, default 120: source image height in pixels.
REQ-004 SHALL have port clk, input, 1: system clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: level-sensitive run request.
REQ-007 SHALL have port zoom_level, input, 3: 3'd1 selects factor F=2 (80x60 output); 3'd0 selects F=4 (40x30 output); any other value is invalid.
REQ-008 SHALL have port pixel_in, input, 8: source pixel, valid one cycle after its read_addr is presented (synchronous ROM).
REQ-009 SHALL have port read_addr, output, 15: source address, registered.
REQ-010 SHALL have port pixel_out, output, 8: averaged pixel, registered.
REQ-011 SHALL have port write_addr, output, 17: destination address, registered.
REQ-012 SHALL have port write_en, output, 1: one-cycle destination write strobe.
REQ-013 SHALL have port done, output, 1: frame complete.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, LAST, WRITE and DONE.
REQ-015 IDLE: when enable=1 and zoom_level is valid, SHALL latch F, clear the block counters bx/by and the accumulator, and go to FETCH; when zoom_level is invalid, SHALL stay in IDLE.
REQ-016 FETCH: SHALL present read_addr = (by*F+dy)*IMG_WIDTH_IN + bx*F + dx, with dx fastest, on F*F consecutive cycles.
REQ-017 FETCH: from its second cycle on, SHALL add pixel_in to the accumulator each cycle.
REQ-018 FETCH SHALL go to LAST after address (dx=F-1, dy=F-1).
REQ-019 LAST: SHALL accumulate the final pixel_in and then go to WRITE.
REQ-020 The accumulator SHALL be 12 bits wide; the maximum value 16*255=4080 SHALL NOT overflow.
REQ-021 WRITE: SHALL hold write_en=1 for exactly one cycle.
REQ-022 WRITE: pixel_out SHALL equal the block sum >> 2 (F=2) or >> 4 (F=4), truncated with no rounding.
REQ-023 WRITE: write_addr SHALL equal by*(IMG_WIDTH_IN/F) + bx, zero-extended to 17 bits.
REQ-024 After WRITE, the block counters SHALL advance bx-fastest; the accumulator SHALL clear and the FSM SHALL re-enter FETCH.
REQ-025 After the last block (bx=IMG_WIDTH_IN/F-1, by=IMG_HEIGHT_IN/F-1) is written, the FSM SHALL go to DONE.
REQ-026 Block latency SHALL be F*F+2 cycles.
REQ-027 Frame time from IDLE exit to DONE entry SHALL be 28800 cycles for F=2 and 21600 cycles for F=4.
REQ-028 DONE: done SHALL be 1 and held while enable=1; write_en SHALL be 0.
REQ-029 DONE: enable=0 SHALL return the FSM to IDLE with done=0 on the next cycle.
REQ-030 enable=0 in FETCH, LAST or WRITE SHALL abort to IDLE on the next edge: counters and accumulator cleared, write_en=0, no partial block written.
REQ-031 Changes on zoom_level after leaving IDLE SHALL be ignored until the next IDLE exit.
REQ-032 write_en SHALL be 0 in every state except WRITE.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE.
REQ-034 rst_n=0 SHALL immediately force read_addr=0, write_addr=0, pixel_out=0, write_en=0, done=0, accumulator=0, bx=0 and by=0.
REQ-035 rst_n assertion mid-frame SHALL discard the partial block.
REQ-036 After rst_n release with enable=1, a new frame SHALL start from block (0,0).

Verification
REQ-037 Bench SHALL cover: reset asserted mid-FETCH -> all outputs 0 asynchronously; with enable=1 on release, the first read_addr=0.
REQ-038 Bench SHALL cover: F=2, uniform image 100 -> 4800 writes, write_addr 0..4799 in order, all pixel_out=100, done exactly 28800 cycles after start.
REQ-039 Bench SHALL cover: F=4, first block -> read_addr sequence 0,1,2,3,160,161,162,163,320..323,480..483, write_addr=0; 1200 writes total, done at cycle 21600.
REQ-040 Bench SHALL cover: F=2, block pixels {1,2,3,4} -> pixel_out=2 (truncation); block {255,255,255,255} -> 255; F=4 all-255 -> 255 (no overflow).
REQ-041 Bench SHALL cover: enable dropped during block 10 -> no write for block 10; on re-enable, restart at write_addr=0.
REQ-042 Bench SHALL cover: zoom_level=3'd2 with enable=1 for 1000 cycles -> stays in IDLE, write_en=0, done=0.
